// File: rtl/ifetch_ir_pkg.sv
// rtl/ifetch_ir_pkg.sv - shared next-PC codes, fetch FSM states and reset PC (IF_ALIGN_CHK_EN adds FAULT)
package ifetch_ir_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
`ifdef IF_ALIGN_CHK_EN
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
`else
        ST_HOLD  = 2'd2
`endif
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ir_npc_calc.sv
// rtl/ifetch_ir_npc_calc.sv - combinational next-PC selection (low bits masked unless IF_ALIGN_CHK_EN)
module ifetch_ir_npc_calc
    import ifetch_ir_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [25:0]       instr_idx_i,
    input  logic [31:0]       br_imm32_i,
    input  logic [31:0]       jr_target_i,
    input  logic [1:0]        npc_op_i,
    output logic [ADDR_W-1:0] npc_o
);

    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] npc_raw;

    assign pc_plus4 = pc_i + ADDR_W'(4);

    // Select the candidate target; all arithmetic wraps at the address width
    always_comb begin
        npc_raw = pc_plus4;
        case (npc_op_i)
            NPC_SEQ: npc_raw = pc_plus4;
            NPC_BR:  npc_raw = pc_plus4 + ADDR_W'({br_imm32_i[29:0], 2'b00});
            NPC_J:   npc_raw = {pc_plus4[ADDR_W-1:28], instr_idx_i, 2'b00};
            NPC_JR:  npc_raw = ADDR_W'(jr_target_i);
            default: npc_raw = pc_plus4;
        endcase
    end

`ifdef IF_ALIGN_CHK_EN
    // Pass misaligned targets through so the fetch FSM can trap on them
    assign npc_o = npc_raw;
`else
    // No fault path exists, so force word alignment
    assign npc_o = {npc_raw[ADDR_W-1:2], 2'b00};
`endif

endmodule

// File: rtl/ifetch_ir.sv
// rtl/ifetch_ir.sv - instruction fetch FSM, PC and IR with decode field split (optional IF_ALIGN_CHK_EN)
module ifetch_ir
    import ifetch_ir_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              id_ready,
    input  logic [1:0]        npc_op,
    input  logic [31:0]       br_imm32,
    input  logic [31:0]       jr_target,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              instr_valid,
    output logic [5:0]        op,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic              if_fault
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic              req_q;
    logic              valid_q;
    logic [ADDR_W-1:0] npc_d;
`ifdef IF_ALIGN_CHK_EN
    logic              fault_q;
`endif

    ifetch_ir_npc_calc #(
        .ADDR_W (ADDR_W)
    ) u_npc_calc (
        .pc_i        (pc_q),
        .instr_idx_i (ir_q[25:0]),
        .br_imm32_i  (br_imm32),
        .jr_target_i (jr_target),
        .npc_op_i    (npc_op),
        .npc_o       (npc_d)
    );

    // Fetch FSM: one outstanding request, IR held until decode consumes it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        ir_q    <= imem_rdata;
                        valid_q <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        pc_q    <= npc_d;
                        valid_q <= 1'b0;
`ifdef IF_ALIGN_CHK_EN
                        if (npc_d[1:0] != 2'b00) begin
                            fault_q <= 1'b1;
                            state_q <= ST_FAULT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= ST_REQ;
                        end
`else
                        req_q   <= 1'b1;
                        state_q <= ST_REQ;
`endif
                    end
                end
`ifdef IF_ALIGN_CHK_EN
                ST_FAULT: begin
                    fault_q <= 1'b1;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = ir_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign instr_valid = valid_q;
    assign op          = ir_q[31:26];
    assign rs          = ir_q[25:21];
    assign rt          = ir_q[20:16];
    assign rd          = ir_q[15:11];
    assign shamt       = ir_q[10:6];
    assign funct       = ir_q[5:0];
    assign imm16       = ir_q[15:0];
`ifdef IF_ALIGN_CHK_EN
    assign if_fault    = fault_q;
`else
    assign if_fault    = 1'b0;
`endif

endmodule
